// File: rtl/bullet_obj.sv
// bullet_obj: player projectile engine. Spawns a SIZE x SIZE bullet beside
// the shooter on a fire edge, steps it horizontally every STEP_DIV+1 cycles
// and repaints it through a shared VGA port using a request/grant handshake.
// Optional macro BULLET_HIT_COUNT_EN adds a saturating hit counter output.
// Ports:
//   CLOCK_50, rst (async, active-high)
//   fire, shooter_X, shooter_Y, hit       - game inputs
//   plot_grant / plot_req                 - VGA port arbitration
//   bullet_X, bullet_Y, bullet_active     - bullet position for collision
//   VGA_X_Pos, VGA_Y_Pos, VGA_Color, VGA_Plot_EN - pixel write port
//   hit_count (BULLET_HIT_COUNT_EN only)  - accepted hits, saturating
module bullet_obj #(
    parameter int         SIZE      = 4,
    parameter int         STEP_DIV  = 255,
    parameter int         DIRECTION = 1,
    parameter int         LAUNCH_DX = 32,
    parameter int         LAUNCH_DY = 14,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 319,
    parameter logic [2:0] COLOR     = 3'b100
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       fire,
    input  logic [8:0] shooter_X,
    input  logic [7:0] shooter_Y,
    input  logic       hit,
    input  logic       plot_grant,
    output logic       plot_req,
    output logic [8:0] bullet_X,
    output logic [7:0] bullet_Y,
    output logic       bullet_active,
    output logic [8:0] VGA_X_Pos,
    output logic [7:0] VGA_Y_Pos,
    output logic [2:0] VGA_Color,
    output logic       VGA_Plot_EN
`ifdef BULLET_HIT_COUNT_EN
    ,
    output logic [7:0] hit_count
`endif
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int SW = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
    localparam logic [CW-1:0] CMAX  = CW'(SIZE - 1);
    localparam logic [SW-1:0] SLOAD = SW'(STEP_DIV);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        DRAW,
        WAIT,
        ERASE,
        MOVE
    } state_t;

    state_t state, state_n;

    logic [8:0]    x_q;
    logic [7:0]    y_q;
    logic [CW-1:0] xc, yc;
    logic [SW-1:0] step_cnt;
    logic          fire_d;
    logic          retire;
    logic          hit_pend;

    logic          fire_edge;
    logic          sweeping;
    logic          last_px;
    logic          tick;
    logic          hit_now;
    logic [8:0]    launch_x;
    logic [7:0]    launch_y;
    logic [8:0]    next_x;

    // Top-left x must keep the whole bullet inside X_MIN..X_MAX.
    function automatic logic legal(input logic [8:0] v);
        return (int'(v) >= X_MIN) && (int'(v) <= X_MAX - SIZE + 1);
    endfunction

    always_comb begin
        fire_edge = fire & ~fire_d;
        if (DIRECTION != 0) begin
            launch_x = shooter_X + 9'(LAUNCH_DX);
            next_x   = x_q + 9'd1;
        end else begin
            launch_x = shooter_X - 9'(SIZE);
            next_x   = x_q - 9'd1;
        end
        launch_y = shooter_Y + 8'(LAUNCH_DY);
        sweeping = (state == DRAW) || (state == ERASE);
        last_px  = sweeping && plot_grant && (xc == CMAX) && (yc == CMAX);
        hit_now  = (state == WAIT) && (hit || hit_pend);
        tick     = (state == WAIT) && (step_cnt == '0);

        state_n = state;
        unique case (state)
            IDLE:   if (fire_edge) state_n = LAUNCH;
            LAUNCH: state_n = legal(launch_x) ? DRAW : IDLE;
            DRAW:   if (last_px) state_n = WAIT;
            // A pending or live hit skips the remaining step delay.
            WAIT:   if (hit_now || tick) state_n = ERASE;
            ERASE:  if (last_px) state_n = retire ? IDLE : MOVE;
            MOVE:   state_n = DRAW;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        plot_req    = sweeping;
        VGA_Plot_EN = sweeping & plot_grant;
        VGA_X_Pos   = '0;
        VGA_Y_Pos   = '0;
        VGA_Color   = '0;
        if (sweeping) begin
            VGA_X_Pos = x_q + 9'(xc);
            VGA_Y_Pos = y_q + 8'(yc);
            VGA_Color = (state == DRAW) ? COLOR : 3'b111;
        end
        bullet_X = x_q;
        bullet_Y = y_q;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            x_q           <= '1;
            y_q           <= '1;
            xc            <= '0;
            yc            <= '0;
            step_cnt      <= '0;
            fire_d        <= 1'b0;
            retire        <= 1'b0;
            hit_pend      <= 1'b0;
            bullet_active <= 1'b0;
        end else begin
            fire_d <= fire;

            if (state == LAUNCH && state_n == DRAW) begin
                x_q           <= launch_x;
                y_q           <= launch_y;
                bullet_active <= 1'b1;
            end

            if (state == MOVE) x_q <= next_x;

            if (state == DRAW && hit) hit_pend <= 1'b1;

            if (state == WAIT && state_n == ERASE) begin
                hit_pend <= 1'b0;
                if (hit_now || !legal(next_x)) retire <= 1'b1;
            end

            if (state == DRAW && last_px) begin
                step_cnt <= SLOAD;
            end else if (state == WAIT && step_cnt != '0) begin
                step_cnt <= step_cnt - SW'(1);
            end

            // Raster sweep: x inner, y outer; advances only when granted.
            if (sweeping && plot_grant) begin
                if (xc == CMAX) begin
                    xc <= '0;
                    yc <= (yc == CMAX) ? '0 : yc + CW'(1);
                end else begin
                    xc <= xc + CW'(1);
                end
            end

            if (state == ERASE && last_px && retire) begin
                x_q           <= '1;
                y_q           <= '1;
                bullet_active <= 1'b0;
                retire        <= 1'b0;
            end
        end
    end

`ifdef BULLET_HIT_COUNT_EN
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (hit && (state == DRAW || state == WAIT)
                     && hit_count != 8'hFF) begin
            hit_count <= hit_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bullet_obj.sv
// tb_bullet_obj: directed bench for bullet_obj.
// Launch table plus hand sequences for sweep, stall, retire, hit, reset.
module tb_bullet_obj;

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic       fire = 1'b0;
    logic [8:0] shooter_X = '0;
    logic [7:0] shooter_Y = '0;
    logic       hit = 1'b0;
    logic       plot_grant = 1'b1;
    logic       plot_req;
    logic [8:0] bullet_X;
    logic [7:0] bullet_Y;
    logic       bullet_active;
    logic [8:0] VGA_X_Pos;
    logic [7:0] VGA_Y_Pos;
    logic [2:0] VGA_Color;
    logic       VGA_Plot_EN;
`ifdef BULLET_HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    int checks = 0;
    int errors = 0;

    bullet_obj #(
        .SIZE(4),
        .STEP_DIV(3)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst(rst),
        .fire(fire),
        .shooter_X(shooter_X),
        .shooter_Y(shooter_Y),
        .hit(hit),
        .plot_grant(plot_grant),
        .plot_req(plot_req),
        .bullet_X(bullet_X),
        .bullet_Y(bullet_Y),
        .bullet_active(bullet_active),
        .VGA_X_Pos(VGA_X_Pos),
        .VGA_Y_Pos(VGA_Y_Pos),
        .VGA_Color(VGA_Color),
        .VGA_Plot_EN(VGA_Plot_EN)
`ifdef BULLET_HIT_COUNT_EN
        ,
        .hit_count(hit_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fire = 1'b0;
        hit = 1'b0;
        plot_grant = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_bx", bullet_X, 9'h1FF);
        chk("rst_by", bullet_Y, 8'hFF);
        chk("rst_act", bullet_active, 0);
        chk("rst_req", plot_req, 0);
        chk("rst_en", VGA_Plot_EN, 0);
        chk("rst_vx", VGA_X_Pos, 0);
        chk("rst_col", VGA_Color, 0);
    endtask

    task automatic launch(input logic [8:0] sx, input logic [7:0] sy);
        shooter_X = sx;
        shooter_Y = sy;
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        step();
    endtask

    task automatic wait_req(input int lim, output int n);
        n = 0;
        while (!plot_req && n < lim) begin
            n++;
            step();
        end
    endtask

    task automatic sweep(input logic [8:0] ex, input logic [7:0] ey,
                         input logic [2:0] ecol, input bit tog,
                         input int hit_at, output int npix,
                         output int ncyc);
        logic [15:0] seen;
        logic [8:0]  px;
        logic [7:0]  py;
        bit          prev_low;
        int          dx, dy;
        seen = '0;
        npix = 0;
        ncyc = 0;
        prev_low = 1'b0;
        px = '0;
        py = '0;
        for (int c = 0; c < 100; c++) begin
            plot_grant = tog ? c[0] : 1'b1;
            hit = (c == hit_at);
            #1;
            if (!plot_req) break;
            ncyc++;
            if (prev_low) begin
                chk("hold_x", VGA_X_Pos, px);
                chk("hold_y", VGA_Y_Pos, py);
            end
            if (VGA_Plot_EN) begin
                dx = int'(VGA_X_Pos) - int'(ex);
                dy = int'(VGA_Y_Pos) - int'(ey);
                chk("pix_col", VGA_Color, ecol);
                if (dx < 0 || dx > 3 || dy < 0 || dy > 3) begin
                    chk("pix_xy", {VGA_X_Pos, VGA_Y_Pos}, {ex, ey});
                end else begin
                    chk("pix_dup", seen[dy*4+dx], 0);
                    seen[dy*4+dx] = 1'b1;
                end
                npix++;
            end
            prev_low = !VGA_Plot_EN;
            px = VGA_X_Pos;
            py = VGA_Y_Pos;
            step();
        end
        plot_grant = 1'b1;
        hit = 1'b0;
        chk("sweep_cover", seen, 16'hFFFF);
    endtask

    typedef struct {
        logic [8:0] sx;
        logic [7:0] sy;
        logic       act;
        logic [8:0] bx;
        logic [7:0] by;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n, npix, ncyc;
        vt[0] = '{9'd100, 8'd50,  1'b1, 9'd132,  8'd64};
        vt[1] = '{9'd284, 8'd10,  1'b1, 9'd316,  8'd24};
        vt[2] = '{9'd285, 8'd10,  1'b0, 9'h1FF,  8'hFF};
        vt[3] = '{9'd480, 8'd0,   1'b1, 9'd0,    8'd14};
        vt[4] = '{9'd300, 8'd250, 1'b0, 9'h1FF,  8'hFF};
        vt[5] = '{9'd0,   8'd241, 1'b1, 9'd32,   8'd255};
        vt[6] = '{9'd511, 8'd200, 1'b1, 9'd31,   8'd214};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            launch(vt[i].sx, vt[i].sy);
            chk("vec_act", bullet_active, vt[i].act);
            chk("vec_bx", bullet_X, vt[i].bx);
            chk("vec_by", bullet_Y, vt[i].by);
        end

        // Full draw / wait / erase / move / redraw cycle.
        do_reset();
        launch(9'd100, 8'd50);
        sweep(9'd132, 8'd64, 3'b100, 1'b0, -1, npix, ncyc);
        chk("draw_npix", npix, 16);
        chk("draw_ncyc", ncyc, 16);
        chk("wait_bx", bullet_X, 132);
        chk("wait_en", VGA_Plot_EN, 0);
        wait_req(50, n);
        chk("wait_len", n, 4);
        sweep(9'd132, 8'd64, 3'b111, 1'b0, -1, npix, ncyc);
        chk("erase_npix", npix, 16);
        wait_req(50, n);
        chk("move_len", n, 1);
        chk("move_bx", bullet_X, 133);
        sweep(9'd133, 8'd64, 3'b100, 1'b0, -1, npix, ncyc);
        chk("redraw_npix", npix, 16);

        // Grant toggling: sweep stalls and holds coordinates.
        do_reset();
        launch(9'd100, 8'd50);
        sweep(9'd132, 8'd64, 3'b100, 1'b1, -1, npix, ncyc);
        chk("tog_npix", npix, 16);
        chk("tog_ncyc", ncyc, 32);

        // Right edge retire, dropped fire edge, held fire, relaunch.
        do_reset();
        launch(9'd284, 8'd10);
        sweep(9'd316, 8'd24, 3'b100, 1'b0, -1, npix, ncyc);
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        wait_req(50, n);
        chk("edge_wait", n, 2);
        sweep(9'd316, 8'd24, 3'b111, 1'b0, -1, npix, ncyc);
        chk("edge_npix", npix, 16);
        chk("edge_act", bullet_active, 0);
        chk("edge_bx", bullet_X, 9'h1FF);
        chk("edge_by", bullet_Y, 8'hFF);
        wait_req(10, n);
        chk("held_fire", n, 10);
        chk("held_act", bullet_active, 0);
        launch(9'd284, 8'd10);
        chk("relaunch_act", bullet_active, 1);
        chk("relaunch_bx", bullet_X, 316);

        // Hit during draw: erase right after wait entry, then retire.
        do_reset();
        launch(9'd108, 8'd50);
        chk("hit_bx", bullet_X, 140);
        sweep(9'd140, 8'd64, 3'b100, 1'b0, 3, npix, ncyc);
        chk("hit_draw_npix", npix, 16);
        wait_req(50, n);
        chk("hit_wait", n, 1);
        sweep(9'd140, 8'd64, 3'b111, 1'b0, -1, npix, ncyc);
        chk("hit_erase_npix", npix, 16);
        chk("hit_act", bullet_active, 0);
        chk("hit_bx_off", bullet_X, 9'h1FF);
`ifdef BULLET_HIT_COUNT_EN
        chk("hit_count", hit_count, 1);
`endif

        // Asynchronous reset in the middle of an erase sweep.
        do_reset();
        launch(9'd100, 8'd50);
        sweep(9'd132, 8'd64, 3'b100, 1'b0, -1, npix, ncyc);
        wait_req(50, n);
        for (int k = 0; k < 5; k++) step();
        chk("mid_erase_req", plot_req, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req", plot_req, 0);
        chk("arst_en", VGA_Plot_EN, 0);
        chk("arst_act", bullet_active, 0);
        chk("arst_bx", bullet_X, 9'h1FF);
        chk("arst_by", bullet_Y, 8'hFF);
        chk("arst_vx", VGA_X_Pos, 0);
        chk("arst_col", VGA_Color, 0);
        fire = 1'b0;
        step();
        rst = 1'b0;
        step();
        launch(9'd100, 8'd50);
        chk("post_rst_act", bullet_active, 1);
        chk("post_rst_bx", bullet_X, 132);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bullet_obj.md
Name: bullet_obj

Overview:
Player-fired projectile engine feeding the collision inputs (enemy_bullet_X/enemy_bullet_Y) of the opposing player's sprite drawer. On a fire edge it spawns a square bullet beside the shooter. It moves the bullet horizontally at a fixed rate and repaints it with an erase/draw pixel sweep through a shared VGA port, using a request/grant handshake. It retires the bullet at the screen edge or on a hit.

Parameters:
SIZE, 4, bullet side in pixels (power of 2, 2..8)
STEP_DIV, 255, WAIT cycles between moves minus 1
DIRECTION, 1, 1 = moves +x, 0 = moves -x
LAUNCH_DX, 32, x offset from shooter_X when DIRECTION=1 (sprite width); DIRECTION=0 uses -SIZE
LAUNCH_DY, 14, y offset from shooter_Y
X_MIN, 0, leftmost legal bullet x
X_MAX, 319, rightmost legal pixel column
COLOR, 3'b100, draw colour

Ports:
CLOCK_50  in  1  clock
rst  in  1  asynchronous active-high reset
fire  in  1  fire button, level
shooter_X  in  9  shooter sprite top-left x
shooter_Y  in  8  shooter sprite top-left y
hit  in  1  collision pulse from target's game_over_en
plot_grant  in  1  VGA port granted this cycle
plot_req  out  1  requesting VGA port
bullet_X  out  9  bullet top-left x; 9'h1FF when inactive
bullet_Y  out  8  bullet top-left y; 8'hFF when inactive
bullet_active  out  1  bullet in flight
VGA_X_Pos  out  9  pixel x
VGA_Y_Pos  out  8  pixel y
VGA_Color  out  3  pixel colour
VGA_Plot_EN  out  1  = plot_req & plot_grant

Behaviour:
- Clock and reset: one clock (CLOCK_50); reset is asynchronous and active-high (rst).
- Reset values: state IDLE; bullet_X=9'h1FF; bullet_Y=8'hFF; bullet_active, plot_req, VGA_Plot_EN, retire flag, fire_d all 0; VGA_X_Pos/VGA_Y_Pos/VGA_Color 0; pixel counters 0.
- Fire detect: fire_d registers fire. Edge = fire & ~fire_d. The edge is honoured only in IDLE; edges in any other state are dropped.
- IDLE -> LAUNCH on the edge at the next clock.
- LAUNCH (1 cycle):
  - x = shooter_X+LAUNCH_DX (DIRECTION=1) or shooter_X-SIZE (DIRECTION=0); y = shooter_Y+LAUNCH_DY; all arithmetic mod 2^9 / 2^8.
  - If launch x is outside X_MIN..X_MAX-SIZE+1, go to IDLE without drawing.
  - Else go to DRAW; bullet_active=1 from DRAW entry.
- DRAW / ERASE:
  - plot_req=1. XC/YC counters (log2(SIZE) bits each) advance only on cycles with plot_grant.
  - VGA_X_Pos = x+XC, VGA_Y_Pos = y+YC. Colour is COLOR in DRAW, 3'b111 in ERASE.
  - The sweep ends on the granted cycle with XC=YC=SIZE-1, so it takes exactly SIZE*SIZE granted cycles. Counters return to 0.
  - DRAW -> WAIT.
- WAIT: plot_req=0. The step counter loads STEP_DIV on entry and decrements; the tick fires when it reaches 0, i.e. STEP_DIV+1 cycles after entry.
  - On tick: next x = x±1. If next x is outside the legal range, set retire. Then go to ERASE.
  - hit=1 in WAIT sets retire and goes to ERASE immediately. hit has priority over the tick.
- hit seen in DRAW is latched and acted on at WAIT entry. hit in IDLE/LAUNCH is ignored.
- ERASE end: if retire, go to IDLE, bullet_active=0, bullet_X/Y return to 9'h1FF/8'hFF, retire=0. Else go to MOVE.
- MOVE (1 cycle): x <= next x; then DRAW.
- bullet_X/bullet_Y always equal the registered x/y while active; they change only in LAUNCH and MOVE.
- plot_grant low mid-sweep stalls the sweep; pixel outputs hold their values.
- rst asserted mid-sweep aborts immediately to reset values. Pixels left on screen are not cleaned up.

Optional Feature:
BULLET_HIT_COUNT_EN: when defined, adds output hit_count [7:0]. Reset 0; +1 on each hit accepted in DRAW or WAIT; saturates at 255. When undefined, the port and counter are absent and the remaining behaviour is identical.

Test Plan:
- SIZE=4, STEP_DIV=3, plot_grant=1, shooter=(100,50), fire 0->1:
  - LAUNCH one cycle after the edge; bullet_X=132, bullet_Y=64.
  - Exactly 16 VGA_Plot_EN cycles with colour 3'b100 covering x 132..135, y 64..67.
  - WAIT lasts 4 cycles, then 16 erase pixels (3'b111), MOVE, redraw at x=133.
- plot_grant toggled 1/0 during DRAW: 16 plot pulses over 32 cycles; coordinates hold during low-grant cycles; no pixel skipped or duplicated.
- Bullet at x=316 (X_MAX=319, SIZE=4) on tick: erase at 316 then IDLE; bullet_active=0; bullet_X=9'h1FF, bullet_Y=8'hFF; no draw at 317.
- hit pulse during DRAW at x=140: DRAW completes; ERASE starts at WAIT entry with no tick wait; then IDLE; hit_count=1 when BULLET_HIT_COUNT_EN is defined.
- Second fire edge while active is ignored; fire held high after retire does not relaunch; a fresh 0->1 edge relaunches.
- rst pulse mid-ERASE: all outputs at reset values asynchronously; a fire edge after release launches normally.
